// File: rtl/reg_view_seg7.sv
`default_nettype none
// ============================================================================
// Module   : reg_view_seg7
// Purpose  : Register-file debug viewer. Latches one 32-bit value per frame
//            and scans it as 8 hex digits on a common-anode 7-segment display.
//            Optional SEG7_LEAD_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module reg_view_seg7 #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  reg_sel,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int               c_PW      = $clog2(REFRESH_DIV);
    localparam logic [c_PW-1:0]  c_TICK_AT = c_PW'(REFRESH_DIV - 1);

    logic [c_PW-1:0] presc_q, presc_d;
    logic [2:0]      digit_q, digit_d;
    logic [31:0]     latch_q, latch_d;
    logic [4:0]      raddr_q;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            w_tick;
    logic            w_blank;
    logic [3:0]      w_nibble;

    function automatic logic [6:0] f_hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_tick   = (presc_q == c_TICK_AT);
    assign w_nibble = latch_q[{digit_q, 2'b00} +: 4];

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    // A slot is blank when it and every more-significant nibble are zero; digit 0 always shows.
    assign w_blank = (digit_q != 3'd0) && ((latch_q >> {digit_q, 2'b00}) == 32'd0);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        presc_d = w_tick ? '0 : presc_q + 1'b1;
        digit_d = w_tick ? digit_q + 3'd1 : digit_q;
        latch_d = latch_q;
        // Capture only at the frame boundary so a frame never mixes two values.
        if (w_tick && (digit_q == 3'd7)) begin
            latch_d = rf_rdata;
        end
        an_d  = ~(8'b1 << digit_q);
        seg_d = f_hex7(w_nibble);
        dp_d  = (digit_q != 3'd4);
        if (w_blank) begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            digit_q <= 3'd0;
            latch_q <= 32'd0;
            raddr_q <= 5'd0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            latch_q <= latch_d;
            raddr_q <= reg_sel;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign rf_raddr = raddr_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule
`default_nettype wire
